// File: rtl/pipe_control_pkg.sv
// Shared types and constants for the pipelined control unit: opcodes, funct codes,
// the per-stage control word layout and the bubble value.
package pipe_control_pkg;

    localparam int unsigned CTRL_W = 27;

    localparam logic [5:0] OP_RTYPE = 6'd1;
    localparam logic [5:0] OP_LW    = 6'd2;
    localparam logic [5:0] OP_SW    = 6'd3;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_MUL = 6'd50;

    // Field order fixes the bit offsets: rs[26:22] ... wb_reg[4:0].
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       d_sel;
        logic       c_sel;
        logic [1:0] alu_sel;
        logic       wr_rd;
        logic       wb_sel;
        logic       wb_en;
        logic [4:0] wb_reg;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_control_if.sv
// Fetch-side instruction handshake between instruction fetch and pipe_control.
interface pipe_control_if;

    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);

endinterface

// File: rtl/pipe_control_ctrl_decode.sv
// Purely combinational instruction decoder: 32-bit instruction to control word plus
// an illegal flag. Illegal instructions decode to the bubble word.
module ctrl_decode
    import pipe_control_pkg::*;
#(
    parameter logic [4:0] SHAMT_KEY = 5'd10
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [5:0] op;
    logic [4:0] rs, rt, rd, shamt;
    logic [5:0] funct;

    assign op    = instr_i[31:26];
    assign rs    = instr_i[25:21];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];
    assign shamt = instr_i[10:6];
    assign funct = instr_i[5:0];

    always_comb begin
        ctrl_o    = BUBBLE;
        illegal_o = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl_o.rs     = rs;
                ctrl_o.rt     = rt;
                ctrl_o.rd     = rd;
                ctrl_o.wb_en  = 1'b1;
                ctrl_o.wb_reg = rd;
                if (shamt != SHAMT_KEY) illegal_o = 1'b1;
                case (funct)
                    FN_ADD:  ctrl_o.alu_sel = 2'b00;
                    FN_SUB:  ctrl_o.alu_sel = 2'b01;
                    FN_AND:  ctrl_o.alu_sel = 2'b10;
                    FN_OR:   ctrl_o.alu_sel = 2'b11;
                    FN_MUL:  ctrl_o.d_sel   = 1'b1;
                    default: illegal_o      = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl_o.rs     = rs;
                ctrl_o.rd     = rd;
                ctrl_o.c_sel  = 1'b1;
                ctrl_o.wb_sel = 1'b1;
                ctrl_o.wb_en  = 1'b1;
                ctrl_o.wb_reg = rt;
            end
            OP_SW: begin
                ctrl_o.rs    = rs;
                ctrl_o.rt    = rt;
                ctrl_o.rd    = rd;
                ctrl_o.c_sel = 1'b1;
                ctrl_o.wr_rd = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
        if (ctrl_o.wb_reg == 5'd0) ctrl_o.wb_en = 1'b0;
        if (illegal_o) ctrl_o = BUBBLE;
    end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control unit: ID register, EX/MEM/WB control-word registers, load-use and
// multiply stalls. Define PIPE_CONTROL_NOFWD_EN for a datapath without forwarding.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter int unsigned MUL_LAT   = 3,
    parameter logic [4:0]  SHAMT_KEY = 5'd10,
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_control_if.slave        fetch,
    input  logic                 flush_i,
    output logic [CTRL_W-1:0]    ex_ctrl_o,
    output logic                 ex_valid_o,
    output logic [CTRL_W-1:0]    mem_ctrl_o,
    output logic                 mem_valid_o,
    output logic [CTRL_W-1:0]    wb_ctrl_o,
    output logic                 wb_valid_o,
    output logic                 stall_o,
    output logic [ILL_CNT_W-1:0] ill_cnt_o
);

    localparam logic [3:0] MulInit = 4'(MUL_LAT - 1);

    logic                 id_valid_q, id_valid_d;
    logic [31:0]          id_instr_q, id_instr_d;
    ctrl_t                ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic                 ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [3:0]           mul_cnt_q, mul_cnt_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    ctrl_t      id_ctrl;
    logic       id_illegal, id_live, use_rt, raw_hazard, hazard, mul_busy, hold_mul;
    logic       ready, xfer;
    logic [4:0] id_rs, id_rt;

    ctrl_decode #(
        .SHAMT_KEY (SHAMT_KEY)
    ) u_decode (
        .instr_i   (id_instr_q),
        .ctrl_o    (id_ctrl),
        .illegal_o (id_illegal)
    );

    function automatic logic writes_src(input ctrl_t w, input logic v, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic chk_rt);
        return v && w.wb_en && (w.wb_reg != 5'd0) &&
               ((w.wb_reg == rs) || (chk_rt && (w.wb_reg == rt)));
    endfunction

    // An illegal word in ID is already a bubble, so it never raises a hazard.
    assign id_live = id_valid_q && !id_illegal;
    assign id_rs   = id_instr_q[25:21];
    assign id_rt   = id_instr_q[20:16];
    assign use_rt  = (id_instr_q[31:26] == OP_RTYPE) || (id_instr_q[31:26] == OP_SW);

`ifdef PIPE_CONTROL_NOFWD_EN
    assign raw_hazard = id_live &&
        (writes_src(ex_q, ex_valid_q && ex_q.wb_sel, id_rs, id_rt, use_rt) ||
         writes_src(ex_q, ex_valid_q, id_rs, id_rt, 1'b1) ||
         writes_src(mem_q, mem_valid_q, id_rs, id_rt, 1'b1));
`else
    assign raw_hazard = id_live &&
        writes_src(ex_q, ex_valid_q && ex_q.wb_sel, id_rs, id_rt, use_rt);
`endif

    assign mul_busy = (mul_cnt_q != 4'd0);
    assign hold_mul = !flush_i && mul_busy;
    assign hazard   = !flush_i && !mul_busy && raw_hazard;
    assign ready    = flush_i || (!mul_busy && !raw_hazard);
    assign xfer     = fetch.instr_valid && ready;

    always_comb begin
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        ex_d        = ex_q;
        ex_valid_d  = ex_valid_q;
        mem_d       = ex_q;
        mem_valid_d = ex_valid_q;
        wb_d        = mem_q;
        wb_valid_d  = mem_valid_q;
        mul_cnt_d   = mul_cnt_q;
        ill_cnt_d   = ill_cnt_q;
        if (flush_i) begin
            id_valid_d  = xfer;
            if (xfer) id_instr_d = fetch.instr;
            ex_d        = BUBBLE;
            ex_valid_d  = 1'b0;
            mem_d       = BUBBLE;
            mem_valid_d = 1'b0;
            mul_cnt_d   = 4'd0;
        end else if (hold_mul) begin
            mem_d       = BUBBLE;
            mem_valid_d = 1'b0;
            mul_cnt_d   = mul_cnt_q - 4'd1;
        end else if (hazard) begin
            ex_d       = BUBBLE;
            ex_valid_d = 1'b0;
        end else begin
            ex_d       = id_live ? id_ctrl : BUBBLE;
            ex_valid_d = id_live;
            id_valid_d = xfer;
            if (xfer) id_instr_d = fetch.instr;
            if (id_live && id_ctrl.d_sel) mul_cnt_d = MulInit;
            if (id_valid_q && id_illegal && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
                ill_cnt_d = ill_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q  <= 1'b0;
            id_instr_q  <= '0;
            ex_q        <= BUBBLE;
            ex_valid_q  <= 1'b0;
            mem_q       <= BUBBLE;
            mem_valid_q <= 1'b0;
            wb_q        <= BUBBLE;
            wb_valid_q  <= 1'b0;
            mul_cnt_q   <= 4'd0;
            ill_cnt_q   <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            ex_q        <= ex_d;
            ex_valid_q  <= ex_valid_d;
            mem_q       <= mem_d;
            mem_valid_q <= mem_valid_d;
            wb_q        <= wb_d;
            wb_valid_q  <= wb_valid_d;
            mul_cnt_q   <= mul_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign fetch.instr_ready = ready;
    assign ex_ctrl_o         = ex_q;
    assign ex_valid_o        = ex_valid_q;
    assign mem_ctrl_o        = mem_q;
    assign mem_valid_o       = mem_valid_q;
    assign wb_ctrl_o         = wb_q;
    assign wb_valid_o        = wb_valid_q;
    assign stall_o           = hold_mul || hazard;
    assign ill_cnt_o         = ill_cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: per-cycle vector table plus hand-written load-use and
// illegal-counter saturation sequences.
module tb_pipe_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    pipe_control_if bus ();
    pipe_control_if sat_bus ();
    assign sat_bus.instr       = bus.instr;
    assign sat_bus.instr_valid = bus.instr_valid;

    logic [26:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic        ex_valid, mem_valid, wb_valid, stall;
    logic [7:0]  ill_cnt;

    logic [26:0] s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
    logic        s_ex_valid, s_mem_valid, s_wb_valid, s_stall;
    logic [1:0]  s_ill_cnt;

    pipe_control u_dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (bus.slave),
        .flush_i     (flush),
        .ex_ctrl_o   (ex_ctrl),
        .ex_valid_o  (ex_valid),
        .mem_ctrl_o  (mem_ctrl),
        .mem_valid_o (mem_valid),
        .wb_ctrl_o   (wb_ctrl),
        .wb_valid_o  (wb_valid),
        .stall_o     (stall),
        .ill_cnt_o   (ill_cnt)
    );

    pipe_control #(
        .ILL_CNT_W (2)
    ) u_sat (
        .clk         (clk),
        .rst         (rst),
        .fetch       (sat_bus.slave),
        .flush_i     (flush),
        .ex_ctrl_o   (s_ex_ctrl),
        .ex_valid_o  (s_ex_valid),
        .mem_ctrl_o  (s_mem_ctrl),
        .mem_valid_o (s_mem_valid),
        .wb_ctrl_o   (s_wb_ctrl),
        .wb_valid_o  (s_wb_valid),
        .stall_o     (s_stall),
        .ill_cnt_o   (s_ill_cnt)
    );

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        vld;
        logic        fl;
        logic        rdy;
        logic        stl;
        logic        exv;
        logic [26:0] exc;
        logic        memv;
        logic        wbv;
        logic [7:0]  ill;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    localparam logic [31:0] I_ADD  = 32'h04221AA0;  // add r3,r1,r2
    localparam logic [31:0] I_SW   = 32'h0C220000;  // sw r2,0(r1)
    localparam logic [31:0] I_ADD0 = 32'h042202A0;  // add r0,r1,r2
    localparam logic [31:0] I_MUL  = 32'h042232B2;  // mul r6,r1,r2
    localparam logic [31:0] I_ILL  = 32'hFC000000;
    localparam logic [31:0] I_BADS = 32'h04221A60;  // add with shamt=9
    localparam logic [31:0] I_LW   = 32'h08240000;  // lw r4,0(r1)
    localparam logic [31:0] I_ADD5 = 32'h04812AA0;  // add r5,r4,r1
    localparam logic [31:0] I_AND  = 32'h04223AA4;  // and r7,r1,r2

    function automatic logic [26:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic d, input logic c,
                                       input logic [1:0] alu, input logic wr, input logic wbs,
                                       input logic wbe, input logic [4:0] wbr);
        return {rs, rt, rd, d, c, alu, wr, wbs, wbe, wbr};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic row(input logic r, input logic [31:0] ins, input logic v, input logic f,
                       input logic rdy, input logic stl, input logic exv, input logic [26:0] exc,
                       input logic memv, input logic wbv, input logic [7:0] ill);
        vec_t e;
        e.rst = r; e.instr = ins; e.vld = v; e.fl = f; e.rdy = rdy; e.stl = stl;
        e.exv = exv; e.exc = exc; e.memv = memv; e.wbv = wbv; e.ill = ill;
        tbl.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [31:0] ins, input logic v, input logic f);
        rst = r;
        bus.instr = ins;
        bus.instr_valid = v;
        flush = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    logic [26:0] c_add, c_sw, c_add0, c_mul, c_lw, c_add5, c_and;
    int n_stall, add_cyc, exp_stall, exp_add_cyc;

    initial begin
        c_add  = mk(1, 2, 3, 0, 0, 2'b00, 0, 0, 1, 3);
        c_sw   = mk(1, 2, 0, 0, 1, 2'b00, 1, 0, 0, 0);
        c_add0 = mk(1, 2, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        c_mul  = mk(1, 2, 6, 1, 0, 2'b00, 0, 0, 1, 6);
        c_lw   = mk(1, 0, 0, 0, 1, 2'b00, 0, 1, 1, 4);
        c_add5 = mk(4, 1, 5, 0, 0, 2'b00, 0, 0, 1, 5);
        c_and  = mk(1, 2, 7, 0, 0, 2'b10, 0, 0, 1, 7);

        // rst instr vld fl | rdy stl exv exc memv wbv ill
        // add, sw, add r0 streamed back to back
        row(0, I_ADD,  1, 0,  1, 0, 0, 0,      0, 0, 0);
        row(0, I_SW,   1, 0,  1, 0, 0, 0,      0, 0, 0);
        row(0, I_ADD0, 1, 0,  1, 0, 1, c_add,  0, 0, 0);
        row(0, 0,      0, 0,  1, 0, 1, c_sw,   1, 0, 0);
        row(0, 0,      0, 0,  1, 0, 1, c_add0, 1, 1, 0);
        row(0, 0,      0, 0,  1, 0, 0, 0,      1, 1, 0);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 1, 0);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 0);
        // mul held two extra cycles in EX, add waits in ID
        row(0, I_MUL,  1, 0,  1, 0, 0, 0,      0, 0, 0);
        row(0, I_ADD,  1, 0,  1, 0, 0, 0,      0, 0, 0);
        row(0, 0,      0, 0,  0, 1, 1, c_mul,  0, 0, 0);
        row(0, 0,      0, 0,  0, 1, 1, c_mul,  0, 0, 0);
        row(0, 0,      0, 0,  1, 0, 1, c_mul,  0, 0, 0);
        row(0, 0,      0, 0,  1, 0, 1, c_add,  1, 0, 0);
        row(0, 0,      0, 0,  1, 0, 0, 0,      1, 1, 0);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 1, 0);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 0);
        // illegal opcode, then bad shamt
        row(0, I_ILL,  1, 0,  1, 0, 0, 0,      0, 0, 0);
        row(0, I_BADS, 1, 0,  1, 0, 0, 0,      0, 0, 0);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 1);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 2);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 2);
        // flush with lw in EX and dependent add in ID; and accepted in the flush cycle
        row(0, I_LW,   1, 0,  1, 0, 0, 0,      0, 0, 2);
        row(0, I_ADD5, 1, 0,  1, 0, 0, 0,      0, 0, 2);
        row(0, I_AND,  1, 1,  1, 0, 1, c_lw,   0, 0, 2);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 2);
        row(0, 0,      0, 0,  1, 0, 1, c_and,  0, 0, 2);
        row(0, 0,      0, 0,  1, 0, 0, 0,      1, 0, 2);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 1, 2);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 2);
        // reset in the middle of a multiply hold
        row(0, I_MUL,  1, 0,  1, 0, 0, 0,      0, 0, 2);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 2);
        row(0, 0,      0, 0,  0, 1, 1, c_mul,  0, 0, 2);
        row(1, 0,      0, 0,  0, 1, 1, c_mul,  0, 0, 2);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 0);
        row(0, 0,      0, 0,  1, 0, 0, 0,      0, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].instr, tbl[i].vld, tbl[i].fl);
            #2;
            chk("instr_ready", i, 32'(bus.instr_ready), 32'(tbl[i].rdy));
            chk("stall", i, 32'(stall), 32'(tbl[i].stl));
            chk("ex_valid", i, 32'(ex_valid), 32'(tbl[i].exv));
            chk("ex_ctrl", i, 32'(ex_ctrl), 32'(tbl[i].exc));
            chk("mem_valid", i, 32'(mem_valid), 32'(tbl[i].memv));
            chk("wb_valid", i, 32'(wb_valid), 32'(tbl[i].wbv));
            chk("ill_cnt", i, 32'(ill_cnt), 32'(tbl[i].ill));
            tick();
        end

        // Load-use: without forwarding the add waits until the load reaches WB.
`ifdef PIPE_CONTROL_NOFWD_EN
        exp_stall = 2;
        exp_add_cyc = 5;
`else
        exp_stall = 1;
        exp_add_cyc = 4;
`endif
        do_reset();
        n_stall = 0;
        add_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) drive(1'b0, I_LW, 1'b1, 1'b0);
            else if (c == 1) drive(1'b0, I_ADD5, 1'b1, 1'b0);
            else drive(1'b0, 32'h0, 1'b0, 1'b0);
            #2;
            if (stall) n_stall++;
            if (ex_valid && (ex_ctrl == c_add5) && (add_cyc < 0)) add_cyc = c;
            if (c == 2) begin
                chk("lu_ex_lw", c, 32'(ex_ctrl), 32'(c_lw));
                chk("lu_ready", c, 32'(bus.instr_ready), 32'd0);
            end
            if (c == 3) chk("lu_ex_bubble", c, 32'(ex_valid), 32'd0);
            tick();
        end
        chk("lu_stall_cycles", 0, 32'(n_stall), 32'(exp_stall));
        chk("lu_add_in_ex", 0, 32'(add_cyc), 32'(exp_add_cyc));

        // Saturation: five illegal words into a 2-bit and an 8-bit counter.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 5) drive(1'b0, I_ILL, 1'b1, 1'b0);
            else drive(1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        #2;
        chk("sat_ill_cnt", 0, 32'(s_ill_cnt), 32'd3);
        chk("ill_cnt_5", 0, 32'(ill_cnt), 32'd5);
        chk("sat_ex_valid", 0, 32'(s_ex_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
